// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: RW control regs, RO status regs, W1C interrupt status with enable mask and irq.
// Write executes on the edge of the later AW/W handshake, read data registers on the AR edge; each path holds its response until B/R ready.
module axil_reg_bank #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_CTRL           = 4,
    parameter int          NUM_STAT           = 4,
    parameter int          NUM_IRQ            = 8,
    parameter logic [31:0] CTRL_RESET_VAL     = 32'h0000_0000
) (
    input  logic                                         ACLK,
    input  logic                                         ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    output logic [NUM_CTRL*32-1:0]                       ctrl_out,
    output logic [NUM_CTRL-1:0]                          ctrl_wr,
    input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*32-1:0] stat_in,
    input  logic [NUM_IRQ-1:0]                           irq_src,
    output logic                                         irq
);

    localparam int          IDX_W        = C_S_AXI_ADDR_WIDTH - 2;
    localparam int          IDX_IRQ_STAT = NUM_CTRL + NUM_STAT;
    localparam int          IDX_IRQ_EN   = IDX_IRQ_STAT + 1;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_chk_dw
        $error("axil_reg_bank: C_S_AXI_DATA_WIDTH must be 32");
    end
    if (NUM_CTRL < 1 || NUM_CTRL > 16 || NUM_STAT < 0 || NUM_STAT > 16) begin : g_chk_nreg
        $error("axil_reg_bank: NUM_CTRL must be 1..16 and NUM_STAT 0..16");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_chk_nirq
        $error("axil_reg_bank: NUM_IRQ must be 1..32");
    end
    if (NUM_CTRL + NUM_STAT + 2 > 2**IDX_W) begin : g_chk_map
        $error("axil_reg_bank: register map does not fit the address width");
    end

    typedef enum logic { W_ACCEPT = 1'b0, W_RESP = 1'b1 } wstate_t;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rstate_t;

    logic             r_live;
    wstate_t          r_wstate;
    wstate_t          w_wstate_nxt;
    rstate_t          r_rstate;
    rstate_t          w_rstate_nxt;
    logic             r_aw_held;
    logic             r_w_held;
    logic [IDX_W-1:0] r_awidx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [1:0]       r_bresp;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic [31:0]      r_ctrl [NUM_CTRL];
    logic [NUM_CTRL-1:0] r_ctrl_wr;
    logic [NUM_IRQ-1:0]  r_irq_status;
    logic [NUM_IRQ-1:0]  r_irq_en;
    logic                r_irq;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_wr_exec;
    logic [IDX_W-1:0] w_awidx;
    logic [31:0]      w_widx;
    logic [31:0]      w_ridx;
    logic [31:0]      w_wdat;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wmask;
    logic [31:0]      w_wsel;
    logic             w_wr_mapped;
    logic [NUM_IRQ-1:0] w_irq_clr;
    logic [31:0]      w_rd_dat;
    logic [1:0]       w_rd_resp;
    logic             w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ---------------- write path ----------------
    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID & S_AXI_WREADY;

    // The later of the two handshakes feeds the execute directly, so a write
    // whose AW and W arrive together completes on the handshake edge.
    assign w_wr_exec = (r_wstate == W_ACCEPT) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_awidx   = r_aw_held ? r_awidx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wdat    = r_w_held ? r_wdata : S_AXI_WDATA;
    assign w_wstrb   = r_w_held ? r_wstrb : S_AXI_WSTRB;
    assign w_widx    = 32'(w_awidx);

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < 4; b++) begin
            w_wmask[8*b +: 8] = {8{w_wstrb[b]}};
        end
    end

    assign w_wsel      = w_wdat & w_wmask;
    assign w_wr_mapped = (w_widx < 32'(NUM_CTRL + NUM_STAT + 2));
    assign w_irq_clr   = (w_wr_exec && (w_widx == 32'(IDX_IRQ_STAT))) ? w_wsel[NUM_IRQ-1:0] : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate <= W_ACCEPT;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_ACCEPT: if (w_wr_exec)    w_wstate_nxt = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_wstate_nxt = W_ACCEPT;
            default:                    w_wstate_nxt = W_ACCEPT;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = r_live & (r_wstate == W_ACCEPT) & ~r_aw_held;
        S_AXI_WREADY  = r_live & (r_wstate == W_ACCEPT) & ~r_w_held;
        S_AXI_BVALID  = (r_wstate == W_RESP);
    end

    assign S_AXI_BRESP = r_bresp;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (r_wstate == W_ACCEPT) begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awidx   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= S_AXI_WDATA;
                    r_wstrb  <= S_AXI_WSTRB;
                end
                if (w_wr_exec) begin
                    r_bresp <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
                end
            end else if (S_AXI_BREADY) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                r_ctrl[k] <= CTRL_RESET_VAL;
            end
            r_ctrl_wr <= '0;
        end else begin
            r_ctrl_wr <= '0;
            if (w_wr_exec) begin
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (w_widx == 32'(k)) begin
                        r_ctrl[k]    <= (r_ctrl[k] & ~w_wmask) | w_wsel;
                        r_ctrl_wr[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_out[32*g +: 32] = r_ctrl[g];
    end
    assign ctrl_wr = r_ctrl_wr;

    // ---------------- interrupts ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_irq_status <= '0;
            r_irq_en     <= '0;
            r_irq        <= 1'b0;
        end else begin
            // A source that is high in the same cycle as a W1C keeps its bit set.
            r_irq_status <= (r_irq_status & ~w_irq_clr) | irq_src;
            if (w_wr_exec && (w_widx == 32'(IDX_IRQ_EN))) begin
                r_irq_en <= (r_irq_en & ~w_wmask[NUM_IRQ-1:0]) | w_wsel[NUM_IRQ-1:0];
            end
            r_irq <= |(r_irq_status & r_irq_en);
        end
    end

    assign irq = r_irq;

    // ---------------- read path ----------------
    assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_ridx  = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);

    always_comb begin
        w_rd_dat  = '0;
        w_rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (w_ridx == 32'(k)) begin
                w_rd_dat  = r_ctrl[k];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (w_ridx == 32'(NUM_CTRL + j)) begin
                w_rd_dat  = stat_in[32*j +: 32];
                w_rd_resp = RESP_OKAY;
            end
        end
        if (w_ridx == 32'(IDX_IRQ_STAT)) begin
            w_rd_dat[NUM_IRQ-1:0] = r_irq_status;
            w_rd_resp             = RESP_OKAY;
        end
        if (w_ridx == 32'(IDX_IRQ_EN)) begin
            w_rd_dat[NUM_IRQ-1:0] = r_irq_en;
            w_rd_resp             = RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs)      w_rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            default:                   w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = r_live & (r_rstate == R_IDLE);
        S_AXI_RVALID  = (r_rstate == R_DATA);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if ((r_rstate == R_IDLE) && w_ar_hs) begin
            r_rdata <= w_rd_dat;
            r_rresp <= w_rd_resp;
        end
    end

    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_RRESP = r_rresp;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: reset, ctrl/status/irq access, strobes, backpressure, unmapped, mid-transaction reset.
module tb_axil_reg_bank;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [5:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] ctrl_out;
    logic [3:0]   ctrl_wr;
    logic [127:0] stat_in;
    logic [7:0]   irq_src;
    logic         irq;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt [4];

    logic [1:0]  resp;
    logic [31:0] rdat;

    axil_reg_bank dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ctrl_out      (ctrl_out),
        .ctrl_wr       (ctrl_wr),
        .stat_in       (stat_in),
        .irq_src       (irq_src),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        for (int k = 0; k < 4; k++) wr_cnt[k] = 0;
    end

    always @(posedge ACLK) begin
        for (int k = 0; k < 4; k++) begin
            if (ctrl_wr[k]) wr_cnt[k] <= wr_cnt[k] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] bresp);
        logic aw_done, w_done, aw_now, w_now;
        aw_done = 1'b0;
        w_done  = 1'b0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (aw_done && w_done) break;
            aw_now = S_AXI_AWVALID & S_AXI_AWREADY;
            w_now  = S_AXI_WVALID & S_AXI_WREADY;
            tick();
            if (aw_now) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_now)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("wr_accept", {aw_done, w_done}, 2'b11);
        chk("wr_bvalid_latency", S_AXI_BVALID, 1'b1);
        bresp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] rresp);
        logic done, ar_now;
        done = 1'b0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            ar_now = S_AXI_ARVALID & S_AXI_ARREADY;
            tick();
            if (ar_now) begin S_AXI_ARVALID = 1'b0; done = 1'b1; end
        end
        S_AXI_ARVALID = 1'b0;
        chk("rd_accept", done, 1'b1);
        chk("rd_rvalid_latency", S_AXI_RVALID, 1'b1);
        data  = S_AXI_RDATA;
        rresp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        ARESETN       = 1'b0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        stat_in       = {32'hCAFE_0003, 32'hCAFE_0002, 32'h1234_5678, 32'hCAFE_0000};
        irq_src       = '0;

        // reset state
        repeat (3) tick();
        chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("rst_resps", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0000);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_ctrl", {ctrl_out, ctrl_wr}, 132'h0);
        chk("rst_irq", irq, 1'b0);
        ARESETN = 1'b1;
        #1;
        chk("rel_readies_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        tick();
        chk("rel_readies_high", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // sequential ctrl writes and readback
        for (int k = 0; k < 4; k++) begin
            axi_write(6'(4 * k), 32'(k + 1), 4'hF, resp);
            chk("ctrl_wr_bresp", resp, 2'b00);
        end
        chk("ctrl_out_seq", ctrl_out, {32'h4, 32'h3, 32'h2, 32'h1});
        chk("ctrl_wr_counts", {wr_cnt[3][3:0], wr_cnt[2][3:0], wr_cnt[1][3:0], wr_cnt[0][3:0]}, 16'h1111);
        for (int k = 0; k < 4; k++) begin
            axi_read(6'(4 * k), rdat, resp);
            chk("ctrl_rd_data", rdat, 32'(k + 1));
            chk("ctrl_rd_resp", resp, 2'b00);
        end

        // byte strobes, and a zero-strobe write still pulses ctrl_wr
        axi_write(6'h04, 32'h0, 4'hF, resp);
        axi_write(6'h04, 32'hAABB_CCDD, 4'b0101, resp);
        axi_read(6'h04, rdat, resp);
        chk("strobe_rd", rdat, 32'h00BB_00DD);
        axi_write(6'h04, 32'hFFFF_FFFF, 4'b0000, resp);
        chk("strobe0_bresp", resp, 2'b00);
        chk("strobe0_ctrl", ctrl_out[63:32], 32'h00BB_00DD);
        chk("strobe0_pulse", wr_cnt[1], 4);

        // W three cycles ahead of AW, then BREADY held low
        S_AXI_WDATA  = 32'h55;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("w_early_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
        tick();
        tick();
        S_AXI_AWADDR  = 6'h08;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("w_early_bvalid", S_AXI_BVALID, 1'b1);
        chk("w_early_ctrl", ctrl_out[95:64], 32'h55);
        chk("w_early_pulse", ctrl_wr, 4'b0100);
        S_AXI_AWADDR  = 6'h0C;
        S_AXI_WDATA   = 32'h66;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
            chk("bp_ctrl3", ctrl_out[127:96], 32'h4);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("bp_release", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b011);
        chk("bp_single_apply", {wr_cnt[2][3:0], wr_cnt[3][3:0]}, 8'h21);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("bp_second_write", {S_AXI_BVALID, ctrl_out[127:96]}, {1'b1, 32'h66});
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;

        // unmapped and status accesses
        axi_write(6'h30, 32'hDEAD_BEEF, 4'hF, resp);
        chk("unmap_bresp", resp, 2'b10);
        chk("unmap_ctrl", ctrl_out, {32'h66, 32'h55, 32'h00BB_00DD, 32'h1});
        axi_read(6'h30, rdat, resp);
        chk("unmap_rd", {rdat, resp}, {32'h0, 2'b10});
        axi_read(6'h28, rdat, resp);
        chk("unmap_rd_28", {rdat, resp}, {32'h0, 2'b10});
        axi_write(6'h14, 32'hFFFF_FFFF, 4'hF, resp);
        chk("stat_wr_bresp", resp, 2'b00);
        axi_read(6'h14, rdat, resp);
        chk("stat_rd", {rdat, resp}, {32'h1234_5678, 2'b00});

        // interrupt enable width, set, lag, W1C and set-wins
        axi_write(6'h24, 32'hFFFF_FFFF, 4'hF, resp);
        axi_read(6'h24, rdat, resp);
        chk("irq_en_width", {rdat, resp}, {32'h0000_00FF, 2'b00});
        axi_write(6'h24, 32'h08, 4'hF, resp);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        chk("irq_lag", irq, 1'b0);
        tick();
        chk("irq_set", irq, 1'b1);
        axi_read(6'h20, rdat, resp);
        chk("irq_stat_rd", rdat, 32'h08);
        axi_write(6'h20, 32'h08, 4'hF, resp);
        chk("irq_w1c_irq", irq, 1'b0);
        axi_read(6'h20, rdat, resp);
        chk("irq_w1c_stat", rdat, 32'h0);
        S_AXI_AWADDR  = 6'h20;
        S_AXI_WDATA   = 32'h08;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        irq_src       = 8'h08;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        irq_src       = 8'h00;
        chk("irq_coincide_bvalid", S_AXI_BVALID, 1'b1);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        axi_read(6'h20, rdat, resp);
        chk("irq_set_wins", rdat, 32'h08);
        chk("irq_after_coincide", irq, 1'b1);

        // reset while a write response is pending
        S_AXI_AWADDR  = 6'h00;
        S_AXI_WDATA   = 32'h77;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("mid_bvalid", {S_AXI_BVALID, ctrl_out[31:0]}, {1'b1, 32'h77});
        #2;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_hs", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 4'b0000);
        chk("mid_rst_ctrl", {ctrl_out, ctrl_wr, irq}, 133'h0);
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        chk("mid_rst_no_resp", S_AXI_BVALID, 1'b0);
        axi_write(6'h0C, 32'h9, 4'hF, resp);
        chk("post_rst_bresp", resp, 2'b00);
        chk("post_rst_ctrl", ctrl_out, {32'h9, 32'h0, 32'h0, 32'h0});
        axi_read(6'h20, rdat, resp);
        chk("post_rst_irq_stat", rdat, 32'h0);
        axi_read(6'h24, rdat, resp);
        chk("post_rst_irq_en", rdat, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
